// File: rtl/cordic_sincos_pipeline.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_sincos_pipeline
//  Purpose  : Fully pipelined rotation-mode CORDIC giving cos and sin of a
//             signed fixed-point radian angle over [-pi, +pi], one per clock.
//  Revision : 1.0  initial release
// ============================================================================
module cordic_sincos_pipeline #(
    parameter int WIDTH  = 22,
    parameter int FRAC   = 19,
    parameter int STAGES = 17,
    parameter int GUARD  = 3,
    parameter int TAG_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] angle_in,
    input  logic [TAG_W-1:0]        tag_in,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] cos_out,
    output logic signed [WIDTH-1:0] sin_out,
    output logic [TAG_W-1:0]        tag_out,
    output logic                    range_err
);

    localparam int IW = WIDTH + GUARD;

    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) for (int k = 0; k < n; k++) r = r * 2.0;
        else        for (int k = 0; k < -n; k++) r = r / 2.0;
        return r;
    endfunction

    function automatic int rnd(input real v);
        return $rtoi(v + 0.5);
    endfunction

    // Power series is only used for |x| <= 0.5, where it converges quickly.
    function automatic real atan_r(input real x);
        real sum, term;
        if (x >= 1.0) return 0.78539816339744830962;
        sum  = 0.0;
        term = x;
        for (int n = 0; n < 60; n++) begin
            sum  = (n % 2 == 0) ? sum + term / (2.0 * n + 1.0) : sum - term / (2.0 * n + 1.0);
            term = term * x * x;
        end
        return sum;
    endfunction

    function automatic real sqrt_r(input real v);
        real g;
        g = (v > 1.0) ? v : 1.0;
        for (int n = 0; n < 40; n++) g = 0.5 * (g + v / g);
        return g;
    endfunction

    function automatic real gain_r();
        real p;
        p = 1.0;
        for (int i = 0; i < STAGES; i++) p = p / sqrt_r(1.0 + pow2(-2 * i));
        return p;
    endfunction

    localparam logic signed [WIDTH-1:0] c_pi_q    = WIDTH'(rnd(3.14159265358979323846 * pow2(FRAC)));
    localparam logic signed [WIDTH-1:0] c_pi_half = c_pi_q >>> 1;
    localparam logic signed [IW-1:0]    c_pi_ext  = {c_pi_q, {GUARD{1'b0}}};
    localparam logic signed [IW-1:0]    c_x0      = IW'(rnd(gain_r() * pow2(FRAC + GUARD)));
    localparam logic signed [IW:0]      c_rnd     = (IW+1)'(2 ** (GUARD - 1));

    // Round half up by dropping GUARD LSBs, then clamp into WIDTH bits.
    function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [IW-1:0] v);
        logic signed [IW:0]    t;
        logic signed [WIDTH:0] q;
        t = {v[IW-1], v} + c_rnd;
        q = t[IW:GUARD];
        if (q[WIDTH] != q[WIDTH-1])
            round_sat = q[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            round_sat = q[WIDTH-1:0];
    endfunction

    logic signed [IW-1:0] r_x     [0:STAGES];
    logic signed [IW-1:0] r_y     [0:STAGES];
    logic signed [IW-1:0] r_z     [0:STAGES];
    logic                 r_neg   [0:STAGES];
    logic                 r_err   [0:STAGES];
    logic                 r_valid [0:STAGES];
    logic [TAG_W-1:0]     r_tag   [0:STAGES];

    logic signed [IW-1:0] w_a_ext;
    logic signed [IW-1:0] w_z0;
    logic                 w_neg;
    logic                 w_err;

    // Fold outer quadrants by +/-pi; the cos/sin sign flip is applied at the output.
    always_comb begin
        w_a_ext = {angle_in, {GUARD{1'b0}}};
        w_z0    = w_a_ext;
        w_neg   = 1'b0;
        w_err   = (angle_in > c_pi_q) || (angle_in < -c_pi_q);
        if (angle_in > c_pi_half) begin
            w_z0  = w_a_ext - c_pi_ext;
            w_neg = 1'b1;
        end else if (angle_in < -c_pi_half) begin
            w_z0  = w_a_ext + c_pi_ext;
            w_neg = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid[0] <= 1'b0;
        end else if (enable) begin
            r_valid[0] <= in_valid;
            r_tag[0]   <= tag_in;
            r_neg[0]   <= w_neg;
            r_err[0]   <= w_err;
            r_x[0]     <= c_x0;
            r_y[0]     <= '0;
            r_z[0]     <= w_z0;
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam logic signed [IW-1:0] c_atan = IW'(rnd(atan_r(pow2(-i)) * pow2(FRAC + GUARD)));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_valid[i+1] <= 1'b0;
            end else if (enable) begin
                r_valid[i+1] <= r_valid[i];
                r_tag[i+1]   <= r_tag[i];
                r_neg[i+1]   <= r_neg[i];
                r_err[i+1]   <= r_err[i];
                if (!r_z[i][IW-1]) begin
                    r_x[i+1] <= r_x[i] - (r_y[i] >>> i);
                    r_y[i+1] <= r_y[i] + (r_x[i] >>> i);
                    r_z[i+1] <= r_z[i] - c_atan;
                end else begin
                    r_x[i+1] <= r_x[i] + (r_y[i] >>> i);
                    r_y[i+1] <= r_y[i] - (r_x[i] >>> i);
                    r_z[i+1] <= r_z[i] + c_atan;
                end
            end
        end
    end

    logic signed [IW-1:0] w_xf;
    logic signed [IW-1:0] w_yf;

    always_comb begin
        w_xf = r_neg[STAGES] ? -r_x[STAGES] : r_x[STAGES];
        w_yf = r_neg[STAGES] ? -r_y[STAGES] : r_y[STAGES];
    end

    // Result registers only move on a valid slot so a presented result persists.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            cos_out   <= '0;
            sin_out   <= '0;
            tag_out   <= '0;
            range_err <= 1'b0;
        end else if (enable) begin
            out_valid <= r_valid[STAGES];
            if (r_valid[STAGES]) begin
                tag_out   <= r_tag[STAGES];
                range_err <= r_err[STAGES];
                cos_out   <= r_err[STAGES] ? '0 : round_sat(w_xf);
                sin_out   <= r_err[STAGES] ? '0 : round_sat(w_yf);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordic_sincos_pipeline.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cordic_sincos_pipeline
//  Purpose  : Self-checking bench: real-valued sin/cos model with a transaction
//             queue, directed corner cases and a randomized sweep.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cordic_sincos_pipeline;

    localparam int  WIDTH  = 22;
    localparam int  FRAC   = 19;
    localparam int  STAGES = 17;
    localparam int  GUARD  = 3;
    localparam int  TAG_W  = 4;
    localparam int  PI_Q   = 1647099;
    localparam int  PI_H   = 823549;
    localparam real ONE    = 524288.0;
    localparam real TOL    = 17.0;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    enable;
    logic                    in_valid;
    logic signed [WIDTH-1:0] angle_in;
    logic [TAG_W-1:0]        tag_in;
    logic                    out_valid;
    logic signed [WIDTH-1:0] cos_out;
    logic signed [WIDTH-1:0] sin_out;
    logic [TAG_W-1:0]        tag_out;
    logic                    range_err;

    cordic_sincos_pipeline #(
        .WIDTH(WIDTH), .FRAC(FRAC), .STAGES(STAGES), .GUARD(GUARD), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .angle_in(angle_in), .tag_in(tag_in), .out_valid(out_valid),
        .cos_out(cos_out), .sin_out(sin_out), .tag_out(tag_out), .range_err(range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     a;
        int     tag;
        longint edge_n;
        bit     lit;
        int     lc;
        int     ls;
        bit     lerr;
    } exp_t;

    exp_t   q[$];
    exp_t   pend;
    exp_t   cur;
    int     total = 0;
    int     bad   = 0;
    longint ecount = 0;
    int     kind  = 0;       // 0 none, 1 advance, 2 hold, 3 reset
    bit     lit_on = 0;
    int     lit_c, lit_s;
    bit     lit_err;
    logic [48:0] snap_d = '0;
    logic        snap_v = 1'b0;

    task automatic chk_i(input string n, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", n, act, exp);
        end
    endtask

    task automatic chk_r(input string n, input real act, input real exp, input real tol);
        real d;
        total++;
        d = act - exp;
        if (d > tol || d < -tol) begin
            bad++;
            $display("FAIL %s: got %0.2f want %0.2f (+/-%0.1f)", n, act, exp, tol);
        end
    endtask

    task automatic check_result(input exp_t e);
        bit  err_exp;
        real r, ec, es, c, s;
        chk_i("latency", ecount - e.edge_n, STAGES + 1);
        chk_i("tag", tag_out, e.tag);
        err_exp = (e.a > PI_Q) || (e.a < -PI_Q);
        chk_i("range_err", range_err, err_exp);
        if (err_exp) begin
            chk_i("err_cos_zero", cos_out, 0);
            chk_i("err_sin_zero", sin_out, 0);
        end else begin
            r  = $itor(e.a) / ONE;
            ec = $cos(r) * ONE;
            es = $sin(r) * ONE;
            c  = $itor(cos_out);
            s  = $itor(sin_out);
            chk_r("cos", c, ec, TOL);
            chk_r("sin", s, es, TOL);
            chk_r("magnitude", (c * c + s * s) / ONE, ONE, 2.0 * TOL);
        end
        if (e.lit) begin
            chk_r("lit_cos", $itor(cos_out), $itor(e.lc), TOL);
            chk_r("lit_sin", $itor(sin_out), $itor(e.ls), TOL);
            chk_i("lit_err", range_err, e.lerr);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            kind = 3;
        end else if (enable) begin
            ecount++;
            kind = 1;
            if (in_valid) begin
                pend.a      = int'(angle_in);
                pend.tag    = int'(tag_in);
                pend.edge_n = ecount;
                pend.lit    = lit_on;
                pend.lc     = lit_c;
                pend.ls     = lit_s;
                pend.lerr   = lit_err;
                q.push_back(pend);
            end
        end else begin
            kind = 2;
        end
    end

    always @(negedge clk) begin
        case (kind)
            3: chk_i("reset_outputs", {out_valid, cos_out, sin_out, tag_out, range_err}, 0);
            2: begin
                chk_i("hold_valid", out_valid, snap_v);
                chk_i("hold_data", {cos_out, sin_out, tag_out, range_err}, snap_d);
            end
            1: begin
                if (out_valid) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_out_valid: got 1 want 0");
                    end else begin
                        cur = q.pop_front();
                        check_result(cur);
                    end
                end else begin
                    chk_i("bubble_hold", {cos_out, sin_out, tag_out, range_err}, snap_d);
                end
            end
            default: ;
        endcase
        snap_v = out_valid;
        snap_d = {cos_out, sin_out, tag_out, range_err};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int tg);
        in_valid = 1'b1;
        angle_in = WIDTH'(a);
        tag_in   = TAG_W'(tg);
        tick();
        in_valid = 1'b0;
        lit_on   = 1'b0;
    endtask

    task automatic send_lit(input int a, input int tg, input int lc, input int ls, input bit le);
        lit_on  = 1'b1;
        lit_c   = lc;
        lit_s   = ls;
        lit_err = le;
        send(a, tg);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
        end
        repeat (3) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        reset = 1'b1; enable = 1'b1; in_valid = 1'b0; angle_in = '0; tag_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Single transaction at 1.0 rad
        send_lit(524288, 5, 283272, 441178, 1'b0);
        drain();

        // Axis angles back-to-back, plus the unfolded half-pi boundary
        send_lit(0, 1, 524288, 0, 1'b0);
        send_lit(823550, 2, 0, 524288, 1'b0);
        send_lit(PI_Q, 3, -524288, 0, 1'b0);
        send_lit(-PI_Q, 4, -524288, 0, 1'b0);
        send_lit(-823550, 5, 0, -524288, 1'b0);
        send_lit(PI_H, 6, 0, 524288, 1'b0);
        send_lit(-PI_H, 7, 0, -524288, 1'b0);
        drain();

        // Folded angle and out-of-range angles
        send(32'h0FFC00, 8);
        send_lit(PI_Q + 1, 9, 0, 0, 1'b1);
        send_lit(-PI_Q - 1, 10, 0, 0, 1'b1);
        send_lit(-(1 << 21), 11, 0, 0, 1'b1);
        drain();

        // Enable dropped for 3 cycles while entering, then while results leave
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                enable = 1'b0; in_valid = 1'b1; angle_in = 22'd12345;
                repeat (3) tick();
                enable = 1'b1; in_valid = 1'b0;
            end
            send(k * 200000 - 700000, k);
        end
        repeat (12) tick();
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        drain();

        // Reset (with enable low) while 10 transactions are in flight
        for (int k = 0; k < 10; k++) send(k * 150000 - 675000, k);
        reset = 1'b1; enable = 1'b0;
        tick();
        reset = 1'b0; enable = 1'b1;
        repeat (30) tick();
        send(300000, 12);
        drain();

        // Randomized sweep with gaps and enable stalls
        for (int n = 0; n < 3000; n++) begin
            enable   = ($urandom_range(0, 9) != 0);
            in_valid = ($urandom_range(0, 4) != 0);
            a        = int'($urandom_range(0, 2 * PI_Q + 200)) - PI_Q - 100;
            angle_in = WIDTH'(a);
            tag_in   = TAG_W'($urandom_range(0, 15));
            lit_on   = 1'b0;
            tick();
        end
        enable = 1'b1; in_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
